dot_acc_4bit: RTL and testbench

DOT_ACC_4BIT -- requirements
Module: dot_acc_4bit

---
 rtl/dot_acc_4bit.sv | 59 +++++
 tb/tb_dot_acc_4bit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dot_acc_4bit.sv
// dot_acc_4bit: streaming dot-product accumulator of 4-bit unsigned operand pairs
// with valid/ready handshakes on both sides, sticky overflow and a saturating beat count.
module dot_acc_4bit #(
  parameter logic [11:0] INIT_ACC = 12'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_a,
  input  logic [3:0]  in_b,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_data,
  output logic        out_ovf,
  output logic [7:0]  out_count
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t      state;
  logic [11:0] acc;
  logic        ovf;
  logic [7:0]  count;
  logic [7:0]  prod;
  logic [12:0] sum;
  logic        take;
  // the first beat of a vector restarts from INIT_ACC instead of the stale result
  always_comb begin
    prod = in_a * in_b;
    sum  = {1'b0, (state == IDLE) ? INIT_ACC : acc} + {5'd0, prod};
    take = in_valid && in_ready;
  end
  assign in_ready  = state != DONE;
  assign out_valid = state == DONE;
  assign out_data  = acc;
  assign out_ovf   = ovf;
  assign out_count = count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      count <= '0;
    end else if (clr) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      count <= '0;
    end else if (take) begin
      acc   <= sum[11:0];
      ovf   <= sum[12] | ((state == ACC) & ovf);
      count <= (state == IDLE) ? 8'd1 : count + {7'd0, count != 8'hff};
      state <= in_last ? DONE : ACC;
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_dot_acc_4bit.sv
// tb_dot_acc_4bit: scoreboard bench; stimulus pushes the expected dot product per vector,
// a monitor pops it on every output handshake.
module tb_dot_acc_4bit;
  localparam logic [11:0] INIT = 12'd0;
  logic        clk = 0, rst_n = 0, clr = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic [3:0]  in_a = 0, in_b = 0;
  logic        in_ready, out_valid, out_ovf;
  logic [11:0] out_data;
  logic [7:0]  out_count;
  typedef struct {int data; int ovf; int cnt;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;
  int m_sum = 0, m_n = 0;
  int or_mode = 0;

  dot_acc_4bit #(.INIT_ACC(INIT)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf), .out_count(out_count)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // out_ready is random unless a test pins it
  initial forever begin
    @(posedge clk);
    #2;
    if (or_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected result", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("data", out_data, e.data);
        chk("ovf", out_ovf, e.ovf);
        chk("count", out_count, e.cnt);
      end
    end
  end

  // called at posedge+2; waits (bounded) for in_ready, issues one accepted beat
  task automatic beat(input logic [3:0] a, input logic [3:0] b, input logic last);
    int w;
    in_valid = 1; in_a = a; in_b = b; in_last = last;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) chk("ready timeout", 0, 1);
    @(posedge clk);
    m_sum += int'(a) * int'(b);
    m_n++;
    if (last) begin
      exp_t e;
      e.data = (int'(INIT) + m_sum) % 4096;
      e.ovf  = (int'(INIT) + m_sum) > 4095;
      e.cnt  = (m_n > 255) ? 255 : m_n;
      sb.push_back(e);
      m_sum = 0;
      m_n = 0;
    end
    #2;
    if (last) chk("latency out_valid", out_valid, 1);
    in_valid = 0; in_a = 4'($urandom); in_b = 4'($urandom); in_last = 1'($urandom);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 200) begin
      gap(1);
      w++;
    end
    chk("drain timeout", sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst out_data", out_data, 0);
    chk("rst out_count", out_count, 0);
    rst_n = 1;
    gap(1);
    // basic vector
    beat(3, 5, 0); beat(2, 7, 0); beat(15, 15, 1);
    chk("basic data", out_data, 254);
    chk("basic count", out_count, 3);
    drain();
    // overflow
    for (int i = 0; i < 19; i++) beat(15, 15, i == 18);
    chk("ovf data", out_data, 179);
    chk("ovf flag", out_ovf, 1);
    drain();
    // backpressure with in_valid toggling in DONE
    or_mode = 1; out_ready = 0;
    beat(2, 3, 0); beat(4, 5, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid; in_a = 4'($urandom); in_b = 4'($urandom); in_last = 1'($urandom);
      @(negedge clk);
      chk("bp in_ready", in_ready, 0);
      chk("bp out_valid", out_valid, 1);
      chk("bp data", out_data, 26);
      chk("bp count", out_count, 2);
      @(posedge clk);
      #2;
    end
    in_valid = 0; or_mode = 2; out_ready = 1;
    gap(1);
    chk("bp idle out_valid", out_valid, 0);
    chk("bp idle in_ready", in_ready, 1);
    chk("bp drained", sb.size(), 0);
    or_mode = 0;
    // abort: clr wins over a valid beat
    beat(7, 7, 0); beat(7, 7, 0);
    clr = 1; in_valid = 1; in_a = 9; in_b = 9; in_last = 1;
    @(posedge clk);
    #2;
    clr = 0; in_valid = 0; m_sum = 0; m_n = 0;
    chk("clr out_valid", out_valid, 0);
    chk("clr count", out_count, 0);
    beat(4, 4, 1);
    chk("abort data", out_data, 16);
    drain();
    // counter saturation
    for (int i = 0; i < 300; i++) beat(1, 1, i == 299);
    chk("sat count", out_count, 255);
    chk("sat data", out_data, 300);
    drain();
    // asynchronous reset mid-vector, mid-cycle
    beat(9, 9, 0); beat(8, 8, 0);
    #1 rst_n = 0;
    #1;
    chk("async out_valid", out_valid, 0);
    chk("async in_ready", in_ready, 1);
    chk("async out_data", out_data, 0);
    chk("async out_ovf", out_ovf, 0);
    chk("async out_count", out_count, 0);
    m_sum = 0; m_n = 0;
    @(posedge clk);
    #2 rst_n = 1;
    beat(5, 6, 1);
    chk("post rst data", out_data, 30);
    drain();
    // random vectors with idle gaps and random operands on idle cycles
    for (int v = 0; v < 25; v++) begin
      int n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        gap($urandom_range(0, 2));
        beat(4'($urandom), 4'($urandom), i == n - 1);
      end
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
